stream_compare: RTL and testbench

Sequential, parametrised successor to the two-operand comparator at the top of the design. It checks two WIDTH-bit streams beat by beat under a per-bit mask and reports a per-beat mismatch flag. Over a framed run it also accumulates a saturating error count, the index of the first mismatching beat, and a final pass/fail verdict. It sits between a stimulus source and the testbench scoreboard, so a bench checks one `done`/`pass` pair instead of hand-written per-vector checks.

---
 rtl/stream_compare.sv | 147 ++++++++++++++
 tb/tb_stream_compare.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/stream_compare.sv
// stream_compare: beat-by-beat masked comparison of two streams with
// per-run statistics (saturating error/beat counts, first error index,
// pass/fail verdict).
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | waiting for start; in_valid ignored, results held
//   ST_RUN    | accepting beats on in_valid; in_last closes the run
//   ST_REPORT | one-cycle done pulse, verdict latched into pass
module stream_compare #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mask,
    output logic             o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [CNT_W-1:0] beat_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             o_q, o_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             mismatch;

    // Masked difference of the current beat
    always_comb begin
        mismatch = |((a ^ b) & mask);
    end

    // Next-state and next-output logic; every output is registered
    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        first_d = first_q;
        beat_d  = beat_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    o_d     = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    first_d = '0;
                    beat_d  = '0;
                end
            end

            ST_RUN: begin
                busy_d = 1'b1;
                if (in_valid) begin
                    o_d = mismatch;
                    if (beat_q != CNT_MAX) begin
                        beat_d = beat_q + 1'b1;
                    end
                    if (mismatch) begin
                        // err_q == 0 marks the first mismatch even after
                        // beat_q has saturated
                        if (err_q == '0) begin
                            first_d = beat_q;
                        end
                        if (err_q != CNT_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                    end
                    if (in_last) begin
                        state_d = ST_REPORT;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_REPORT: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                pass_d  = (err_q == '0);
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset taking priority over all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
            beat_q  <= beat_d;
        end
    end

    assign o             = o_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign beat_count    = beat_q;

endmodule

// File: tb/tb_stream_compare.sv
// Bench for stream_compare: a directed vector table against an 8-bit
// counter instance, plus hand-written sequences for reset, saturation
// (shared stimulus into a 2-bit counter instance) and abort/restart.
module tb_stream_compare;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, in_last;
    logic [1:0] a, b, mask;

    logic       o8, busy8, done8, pass8;
    logic [7:0] err8, first8, beat8;
    logic       o2, busy2, done2, pass2;
    logic [1:0] err2, first2, beat2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_compare #(.WIDTH(2), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
        .a(a), .b(b), .mask(mask),
        .o(o8), .busy(busy8), .done(done8), .pass(pass8),
        .err_count(err8), .first_err_idx(first8), .beat_count(beat8)
    );

    stream_compare #(.WIDTH(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
        .a(a), .b(b), .mask(mask),
        .o(o2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_idx(first2), .beat_count(beat2)
    );

    typedef struct {
        logic       st, v, l;
        logic [1:0] a, b, m;
        logic       o, busy, done, pass;
        logic [7:0] e, f, bc;
    } vec_t;

    localparam int NVEC = 28;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic st, input logic v, input logic l,
                                input logic [1:0] va, input logic [1:0] vb, input logic [1:0] vm,
                                input logic eo, input logic ebusy, input logic edone, input logic epass,
                                input logic [7:0] ee, input logic [7:0] ef, input logic [7:0] ebc);
        vec_t r;
        r.st = st; r.v = v; r.l = l; r.a = va; r.b = vb; r.m = vm;
        r.o = eo; r.busy = ebusy; r.done = edone; r.pass = epass;
        r.e = ee; r.f = ef; r.bc = ebc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic l,
                         input logic [1:0] va, input logic [1:0] vb, input logic [1:0] vm);
        start = st; in_valid = v; in_last = l; a = va; b = vb; mask = vm;
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic eo, input logic ebusy, input logic edone,
                        input logic epass, input logic [7:0] ee, input logic [7:0] ef,
                        input logic [7:0] ebc);
        chk({tag, ".o"}, 32'(o8), 32'(eo));
        chk({tag, ".busy"}, 32'(busy8), 32'(ebusy));
        chk({tag, ".done"}, 32'(done8), 32'(edone));
        chk({tag, ".pass"}, 32'(pass8), 32'(epass));
        chk({tag, ".err_count"}, 32'(err8), 32'(ee));
        chk({tag, ".first_err_idx"}, 32'(first8), 32'(ef));
        chk({tag, ".beat_count"}, 32'(beat8), 32'(ebc));
    endtask

    initial begin
        //               st v l  a  b  m   o busy done pass err first beat
        tbl[0]  = mk(1, 0, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 3, 3, 3,  0, 1, 0, 0, 0, 0, 1);
        tbl[2]  = mk(0, 1, 1, 0, 1, 3,  1, 1, 1, 0, 1, 1, 2);
        tbl[3]  = mk(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 1, 1, 2);
        tbl[4]  = mk(1, 0, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 1, 2, 3, 2,  0, 1, 1, 0, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 2,  0, 0, 0, 1, 0, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 1, 2, 3, 1,  1, 1, 1, 0, 1, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 1, 0, 1);
        tbl[10] = mk(0, 1, 1, 0, 3, 3,  1, 0, 0, 0, 1, 0, 1);
        tbl[11] = mk(0, 1, 0, 1, 0, 3,  1, 0, 0, 0, 1, 0, 1);
        tbl[12] = mk(1, 0, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 1, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0, 1);
        tbl[14] = mk(0, 1, 0, 1, 0, 3,  1, 1, 0, 0, 1, 1, 2);
        tbl[15] = mk(1, 0, 0, 0, 0, 3,  1, 1, 0, 0, 1, 1, 2);
        tbl[16] = mk(0, 0, 0, 3, 0, 3,  1, 1, 0, 0, 1, 1, 2);
        tbl[17] = mk(0, 0, 1, 3, 0, 3,  1, 1, 0, 0, 1, 1, 2);
        tbl[18] = mk(1, 1, 0, 3, 3, 3,  0, 1, 0, 0, 1, 1, 3);
        tbl[19] = mk(0, 1, 0, 2, 0, 3,  1, 1, 0, 0, 2, 1, 4);
        tbl[20] = mk(0, 1, 1, 0, 0, 3,  0, 1, 1, 0, 2, 1, 5);
        tbl[21] = mk(0, 0, 0, 0, 0, 3,  0, 0, 0, 0, 2, 1, 5);
        tbl[22] = mk(1, 0, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0, 0);
        tbl[23] = mk(0, 1, 1, 2, 2, 3,  0, 1, 1, 0, 0, 0, 1);
        tbl[24] = mk(0, 0, 0, 0, 0, 3,  0, 0, 0, 1, 0, 0, 1);
        tbl[25] = mk(1, 0, 0, 0, 0, 3,  0, 1, 0, 0, 0, 0, 0);
        tbl[26] = mk(0, 1, 1, 1, 2, 0,  0, 1, 1, 0, 0, 0, 1);
        tbl[27] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1);

        // Reset with random inputs, start/in_valid forced high to test priority
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; in_valid = 1'b1; in_last = 1'($urandom_range(0, 1));
            a = 2'($urandom_range(0, 3)); b = 2'($urandom_range(0, 3));
            mask = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        chk8("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset.busy2", 32'(busy2), 32'd0);
        chk("reset.beat2", 32'(beat2), 32'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].l, tbl[i].a, tbl[i].b, tbl[i].m);
            chk8($sformatf("vec%0d", i), tbl[i].o, tbl[i].busy, tbl[i].done, tbl[i].pass,
                 tbl[i].e, tbl[i].f, tbl[i].bc);
        end

        // Saturation: five mismatching beats into both counter widths
        drive(1, 0, 0, 0, 0, 3);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, (i == 4), 1, 0, 3);
            chk($sformatf("sat%0d.beat2", i), 32'(beat2), (i < 3) ? i + 1 : 3);
            chk($sformatf("sat%0d.err2", i), 32'(err2), (i < 3) ? i + 1 : 3);
        end
        chk("sat.done2", 32'(done2), 32'd1);
        chk("sat.first2", 32'(first2), 32'd0);
        chk8("sat8", 1, 1, 1, 0, 5, 0, 5);
        drive(0, 0, 0, 0, 0, 3);
        chk("sat.pass2", 32'(pass2), 32'd0);
        chk("sat.busy2", 32'(busy2), 32'd0);
        chk("sat.err2_hold", 32'(err2), 32'd3);

        // Abort: reset after two accepted beats, with a last beat presented
        drive(1, 0, 0, 0, 0, 3);
        drive(0, 1, 0, 0, 0, 3);
        drive(0, 1, 0, 2, 1, 3);
        chk8("pre_abort", 1, 1, 0, 0, 1, 1, 2);
        rst = 1'b1;
        drive(0, 1, 1, 2, 1, 3);
        chk8("abort", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 1, 1, 2, 1, 3);
        chk8("abort_idle", 0, 0, 0, 0, 0, 0, 0);

        // Restart with one matching last beat
        drive(1, 0, 0, 0, 0, 3);
        chk8("restart_start", 0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 1, 3);
        chk8("restart_done", 0, 1, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 3);
        chk8("restart_pass", 0, 0, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 3);
        chk("pass_held", 32'(pass8), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
